// File: rtl/wb_byte_master.sv
// Byte-stream command port to single-access 32-bit Wishbone initiator.
// Intended as a debug/boot loader behind a UART receiver/transmitter pair.
module wb_byte_master #(
  parameter int AW   = 32,
  parameter int DW   = 128,
  parameter int TO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd_data,
  output logic              o_cmd_ready,
  output logic              o_rsp_valid,
  output logic [7:0]        o_rsp_data,
  input  logic              i_rsp_ready,
  output logic [AW-1:0]     o_wb_adr,
  output logic [DW/8-1:0]   o_wb_sel,
  output logic              o_wb_we,
  output logic [DW-1:0]     o_wb_dat,
  input  logic [DW-1:0]     i_wb_dat,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  output logic              o_busy
);

  localparam int LANES = DW / 32;
  localparam int SW    = DW / 8;
  localparam int IW    = $clog2(DW);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]      state;
  logic [1:0]      cnt;
  logic            is_wr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rsp_buf;
  logic [2:0]      rsp_left;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     lane;
  logic [IW-1:0]   lane_lo;
  logic            cmd_fire;
  logic            rsp_fire;
  logic            to_hit;

  // Lane of the 32-bit word inside the wide bus word
  assign lane     = (addr >> 2) & 32'(LANES - 1);
  assign lane_lo  = IW'(lane * 32);

  assign o_cmd_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign o_busy      = (state != IDLE);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign rsp_fire    = o_rsp_valid && i_rsp_ready;
  assign to_hit      = &to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      rsp_buf     <= '0;
      rsp_left    <= '0;
      to_cnt      <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_wb_adr    <= '0;
      o_wb_sel    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_dat    <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cnt <= '0;
            if (i_cmd_data == 8'h57) begin
              is_wr <= 1'b1;
              state <= ADDR;
            end else if (i_cmd_data == 8'h52) begin
              is_wr <= 1'b0;
              state <= ADDR;
            end else begin
              o_rsp_valid <= 1'b1;
              o_rsp_data  <= 8'h3F;
              rsp_left    <= '0;
              state       <= RESP;
            end
          end
        end
        ADDR: begin
          if (cmd_fire) begin
            addr <= {addr[23:0], i_cmd_data};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              to_cnt <= '0;
              state  <= is_wr ? DATA : BUS;
            end
          end
        end
        DATA: begin
          if (cmd_fire) begin
            wdata <= {wdata[23:0], i_cmd_data};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              to_cnt <= '0;
              state  <= BUS;
            end
          end
        end
        BUS: begin
          if (!o_wb_cyc) begin
            // First BUS cycle launches the access; cyc stays low until here
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= is_wr;
            o_wb_adr <= AW'(addr & ~32'h3);
            o_wb_sel <= SW'(4'hF) << (lane * 4);
            o_wb_dat <= {LANES{wdata}};
            to_cnt   <= to_cnt + 1'b1;
          end else if (i_wb_err || i_wb_ack || to_hit) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_rsp_valid <= 1'b1;
            rsp_left    <= '0;
            state       <= RESP;
            if (i_wb_err) begin
              o_rsp_data <= 8'h45;
            end else if (i_wb_ack) begin
              o_rsp_data <= 8'h4B;
              if (!is_wr) begin
                rsp_buf  <= i_wb_dat[lane_lo +: 32];
                rsp_left <= 3'd4;
              end
            end else begin
              o_rsp_data <= 8'h54;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            if (rsp_left == 3'd0) begin
              o_rsp_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              o_rsp_data <= rsp_buf[31:24];
              rsp_buf    <= {rsp_buf[23:0], 8'h00};
              rsp_left   <= rsp_left - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
